// File: rtl/atm_transaction_ctrl.sv
// rtl/atm_transaction_ctrl.sv - ATM card-session controller: PIN retries, balance operations, inactivity timeout, card retention
module atm_transaction_ctrl #(
  parameter int balance_width  = 20,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 15,
  parameter int timer_width    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_valid,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [balance_width-1:0] balance_out,
  output logic                     insufficient,
  output logic                     overflow_err,
  output logic                     timeout,
  output logic                     card_retain
);

  localparam int TRY_W = $clog2(max_tries + 1);
  localparam logic [TRY_W-1:0]       TRY_LIMIT = TRY_W'(max_tries);
  localparam logic [timer_width-1:0] TIMER_END = timer_width'(timeout_cycles - 1);

  localparam logic [1:0] OP_INQUIRY  = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_EXIT     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AUTH,
    S_CHECK,
    S_MENU,
    S_EXEC,
    S_SETTLE,
    S_RETAIN
  } state_t;

  state_t                   state_q, state_d;
  logic [TRY_W-1:0]         tries_q, tries_d;
  logic [timer_width-1:0]   timer_q, timer_d;
  logic [1:0]               op_code_q, op_code_d;
  logic [balance_width-1:0] amount_q, amount_d;
  logic                     op_done_q, op_done_d;
  logic [balance_width-1:0] upd_bal_q, upd_bal_d;
  logic [balance_width-1:0] bal_out_q, bal_out_d;
  logic                     insuff_q, insuff_d;
  logic                     ovf_q, ovf_d;
  logic                     timeout_q, timeout_d;
  logic                     retain_q, retain_d;

  // One extra bit so a deposit that does not fit shows up as a carry
  logic [balance_width:0]   dep_sum;
  assign dep_sum = {1'b0, balance} + {1'b0, amount_q};

  // Next-state and next-output logic for the whole session
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    op_code_d = op_code_q;
    amount_d  = amount_q;
    op_done_d = 1'b0;
    upd_bal_d = upd_bal_q;
    bal_out_d = bal_out_q;
    insuff_d  = insuff_q;
    ovf_d     = ovf_q;
    timeout_d = 1'b0;
    retain_d  = retain_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (card_in) begin
          state_d   = S_AUTH;
          tries_d   = '0;
          upd_bal_d = '0;
          bal_out_d = '0;
        end
      end

      S_AUTH: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (psw_valid) begin
          state_d = S_CHECK;
          timer_d = '0;
        end else if (timer_q == TIMER_END) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + timer_width'(1);
        end
      end

      S_CHECK: begin
        timer_d = '0;
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (!wrong_psw) begin
          state_d = S_MENU;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          if (tries_d == TRY_LIMIT) begin
            state_d  = S_RETAIN;
            retain_d = 1'b1;
          end else begin
            state_d = S_AUTH;
          end
        end
      end

      S_MENU: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (op_valid) begin
          timer_d = '0;
          if (op_code == OP_EXIT) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_EXEC;
            op_code_d = op_code;
            amount_d  = amount;
          end
        end else if (timer_q == TIMER_END) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + timer_width'(1);
        end
      end

      // The operation is committed even if the card leaves in this cycle
      S_EXEC: begin
        op_done_d = 1'b1;
        insuff_d  = 1'b0;
        ovf_d     = 1'b0;
        upd_bal_d = balance;
        case (op_code_q)
          OP_WITHDRAW: begin
            if (amount_q > balance) insuff_d  = 1'b1;
            else                    upd_bal_d = balance - amount_q;
          end
          OP_DEPOSIT: begin
            if (dep_sum[balance_width]) ovf_d     = 1'b1;
            else                        upd_bal_d = dep_sum[balance_width-1:0];
          end
          default: upd_bal_d = balance;
        endcase
        bal_out_d = upd_bal_d;
        state_d   = card_in ? S_SETTLE : S_IDLE;
      end

      // Gives the card handler a cycle to apply the committed balance
      S_SETTLE: begin
        timer_d = '0;
        state_d = card_in ? S_MENU : S_IDLE;
      end

      S_RETAIN: begin
        if (!card_in) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Returning to IDLE ends the session: drop error flags and retention
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      insuff_d = 1'b0;
      ovf_d    = 1'b0;
      retain_d = 1'b0;
      timer_d  = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tries_q   <= '0;
      timer_q   <= '0;
      op_code_q <= '0;
      amount_q  <= '0;
      op_done_q <= 1'b0;
      upd_bal_q <= '0;
      bal_out_q <= '0;
      insuff_q  <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
      retain_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      op_code_q <= op_code_d;
      amount_q  <= amount_d;
      op_done_q <= op_done_d;
      upd_bal_q <= upd_bal_d;
      bal_out_q <= bal_out_d;
      insuff_q  <= insuff_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      retain_q  <= retain_d;
    end
  end

  assign op_done         = op_done_q;
  assign updated_balance = upd_bal_q;
  assign balance_out     = bal_out_q;
  assign insufficient    = insuff_q;
  assign overflow_err    = ovf_q;
  assign timeout         = timeout_q;
  assign card_retain     = retain_q;

endmodule

// File: doc/atm_transaction_ctrl.md
Name: atm_transaction_ctrl

Overview:
- Session/transaction controller at the far end of the card-handling interface.
- Consumes `balance` and `wrong_psw` from the card handler; produces `op_done` and `updated_balance` back to it.
- Sequences one card session: password check with retry limit, then inquiry/withdraw/deposit operations and exit.
- Provides inactivity timeout and card retention after too many wrong passwords.

Parameters:
- balance_width, 20, width of balance, amount and updated_balance
- max_tries, 3, wrong-password attempts allowed before card is retained
- timeout_cycles, 15, idle cycles in AUTH/MENU before session abort
- timer_width, 4, width of timeout counter (must hold timeout_cycles)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- card_in  in  1  card present (same signal driven to card handler)
- psw_valid  in  1  user submitted password this cycle
- wrong_psw  in  1  card-handler verdict, valid one cycle after psw_valid
- balance  in  balance_width  current account balance from card handler
- op_valid  in  1  operation request strobe
- op_code  in  2  00 inquiry, 01 withdraw, 10 deposit, 11 exit
- amount  in  balance_width  withdraw/deposit amount
- op_done  out  1  one-cycle pulse: card handler commits updated_balance
- updated_balance  out  balance_width  balance to write back
- balance_out  out  balance_width  balance shown to user, latched at op completion
- insufficient  out  1  withdraw rejected, amount > balance
- overflow_err  out  1  deposit rejected, sum exceeds 2^balance_width-1
- timeout  out  1  one-cycle pulse on inactivity abort
- card_retain  out  1  card retained

Behaviour:
- Reset (rst=0 at edge): state IDLE, try counter 0, timer 0, all outputs 0. Reset overrides every state, including EXEC.
- States: IDLE, AUTH, CHECK, MENU, EXEC, SETTLE, RETAIN.
- IDLE: card_in=1 → AUTH; timer cleared; try counter cleared.
- AUTH:
  - psw_valid=1 → CHECK; timer cleared.
  - Otherwise timer increments; timer==timeout_cycles-1 → IDLE with timeout pulse.
- CHECK: one cycle; samples wrong_psw.
  - wrong_psw=0 → MENU.
  - wrong_psw=1: try counter +1. New count == max_tries → RETAIN; else → AUTH.
- MENU:
  - op_valid=1 with op_code 11 → IDLE, no op_done.
  - op_valid=1 with any other op_code → EXEC; op_code and amount are registered.
  - No op_valid: timer increments, with the same timeout rule as AUTH.
- EXEC: one cycle; op_done=1; insufficient/overflow_err registered for that op.
  - Inquiry: updated_balance = balance.
  - Withdraw with amount <= balance: updated_balance = balance - amount.
  - Withdraw with amount > balance: updated_balance = balance; insufficient=1.
  - Deposit: computed with a balance_width+1-bit sum. On carry, updated_balance = balance and overflow_err=1; else updated_balance = balance + amount.
  - Amount 0 is legal; balance is unchanged.
- SETTLE: one cycle, lets the card handler's balance update → MENU.
- Latency from op_valid:
  - op_valid sampled at edge k → op_done high after edge k+1, low after edge k+2.
  - op_valid is ignored in EXEC/SETTLE.
  - Next accepted op_valid is at edge k+3.
- Error flags hold until the next EXEC or IDLE entry.
- balance_out latches updated_balance at EXEC.
- RETAIN: card_retain=1; ignores all inputs except rst and card_in. card_in=0 → IDLE, which clears card_retain.
- card_in=0 in AUTH/CHECK/MENU/EXEC/SETTLE → IDLE next edge.
  - In EXEC the op_done pulse already issued stands.
  - card_in low has priority over psw_valid/op_valid in the same cycle.
- In IDLE: op_done=0 and timeout=0. updated_balance and balance_out keep their last values until card_in=1 clears them to 0.

Test Plan:
- Reset mid-EXEC: rst=0 while op_done=1 → next edge all outputs 0, state IDLE.
- Correct password, balance=1000, withdraw 300 → op_done pulse, updated_balance=700, insufficient=0; after SETTLE, inquiry → updated_balance equals new balance 700.
- balance=100, withdraw 101 → op_done=1, updated_balance=100, insufficient=1. Withdraw 100 → updated_balance=0, insufficient=0.
- balance=2^20-10, deposit 10 → overflow_err=1, updated_balance unchanged. Deposit 9 → updated_balance=2^20-1.
- Three consecutive wrong_psw=1 → card_retain=1 after 3rd CHECK; psw_valid ignored; card_in=0 → card_retain=0, IDLE.
- Card inserted, no input for 15 cycles in AUTH → timeout pulse, IDLE; same in MENU. Exit op 11 → IDLE with no op_done.
